t_counter_ctrl: RTL and testbench

- Sequencing controller for a bank of WIDTH T flip-flops (T, CP -> Q, QB). The bank has no reset.
- The controller drives every T input each cycle so the bank forms a modulo-(MOD+1) up/down counter with start, clear, pause and resume control.
- It reads the bank's Q outputs as feedback and produces the T enables combinationally. The bank and the controller share clock CP.

---
 rtl/t_counter_ctrl.sv | 99 +++++++++
 tb/tb_t_counter_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/t_counter_ctrl.sv
// Sequencing controller that turns an external, reset-less bank of T flip-flops
// into a modulo-(MOD+1) up/down counter with start/clear/pause/resume control.
module t_counter_ctrl #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              CP,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic              DIR,
  input  logic [WIDTH-1:0]  MOD,
  input  logic [WIDTH-1:0]  Q_IN,
  output logic [WIDTH-1:0]  T_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [WRAP_W-1:0] WRAPS,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    HOLD  = 2'b11
  } state_t;

  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] up_t, dn_t, t_d;
  logic             wrap;

  // Ripple-style toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  for (genvar i = 0; i < WIDTH; i++) begin : g_tbit
    if (i == 0) begin : g_lsb
      assign up_t[i] = 1'b1;
      assign dn_t[i] = 1'b1;
    end else begin : g_upper
      assign up_t[i] = &Q_IN[i-1:0];
      assign dn_t[i] = ~|Q_IN[i-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = '0;
    wrap    = 1'b0;
    case (state_q)
      IDLE: if (START && !STOP) state_d = CLEAR;
      CLEAR: begin
        t_d     = Q_IN;
        state_d = RUN;
      end
      RUN: begin
        if (DIR) begin
          if (Q_IN == MOD) begin
            t_d  = Q_IN;
            wrap = 1'b1;
          end else begin
            t_d = up_t;
          end
        end else begin
          if (Q_IN == '0) begin
            t_d  = Q_IN ^ MOD;
            wrap = 1'b1;
          end else begin
            t_d = dn_t;
          end
        end
        if (STOP) state_d = HOLD;
      end
      HOLD: begin
        if (STOP)       state_d = IDLE;
        else if (START) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must also freeze the bank on the reset edge itself.
  assign T_OUT = RST ? '0 : t_d;
  assign BUSY  = (state_q == CLEAR) || (state_q == RUN);
  assign STATE = state_q;

  always_ff @(posedge CP) begin
    if (RST) begin
      state_q <= IDLE;
      DONE    <= 1'b0;
      WRAPS   <= '0;
    end else begin
      state_q <= state_d;
      DONE    <= wrap;
      if (state_q == CLEAR) WRAPS <= '0;
      else if (wrap)        WRAPS <= WRAPS + WRAP_ONE;
    end
  end

endmodule

// File: tb/tb_t_counter_ctrl.sv
// Directed bench: a T flip-flop bank model closes the loop; expected post-edge
// values are queued by the stimulus and checked by an independent monitor.
module tb_t_counter_ctrl;

  localparam logic [1:0] S_I = 2'b00, S_C = 2'b01, S_R = 2'b10, S_H = 2'b11;

  typedef struct {
    logic [3:0] q;
    logic [1:0] st;
    logic       done;
    logic [7:0] wraps;
  } exp_t;

  logic       CP = 1'b0;
  logic       RST = 1'b1, START = 1'b0, STOP = 1'b0, DIR = 1'b1;
  logic [3:0] MOD = 4'd9;
  logic [3:0] T_OUT;
  logic       BUSY, DONE;
  logic [7:0] WRAPS;
  logic [1:0] STATE;
  logic [3:0] bank = 4'b1011;

  logic       cur_dir = 1'b1;
  logic [3:0] cur_mod = 4'd9;
  int         n_vec = 0, n_err = 0;
  exp_t       sb[$];

  t_counter_ctrl #(.WIDTH(4), .WRAP_W(8)) dut (
    .CP(CP), .RST(RST), .START(START), .STOP(STOP), .DIR(DIR), .MOD(MOD),
    .Q_IN(bank), .T_OUT(T_OUT), .BUSY(BUSY), .DONE(DONE), .WRAPS(WRAPS),
    .STATE(STATE)
  );

  always #5 CP = ~CP;

  // The controlled T flip-flop bank: no reset, toggles where T is high.
  always @(posedge CP) bank <= bank ^ T_OUT;

  task automatic step(input logic rst, input logic st, input logic sp,
                      input logic [3:0] eq, input logic [1:0] es,
                      input logic ed, input logic [7:0] ew);
    exp_t e;
    @(negedge CP);
    RST = rst; START = st; STOP = sp; DIR = cur_dir; MOD = cur_mod;
    e.q = eq; e.st = es; e.done = ed; e.wraps = ew;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    logic eb;
    forever begin
      @(posedge CP);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        eb = (e.st == S_C) || (e.st == S_R);
        n_vec++;
        if (bank !== e.q || STATE !== e.st || DONE !== e.done ||
            WRAPS !== e.wraps || BUSY !== eb) begin
          n_err++;
          $display("FAIL vec%0d: got bank=%b st=%b done=%b wraps=%0d busy=%b, want bank=%b st=%b done=%b wraps=%0d busy=%b",
                   n_vec, bank, STATE, DONE, WRAPS, BUSY, e.q, e.st, e.done, e.wraps, eb);
        end
      end
    end
  end

  initial begin
    // Reset for two edges: bank keeps its preload 1011.
    step(1, 0, 0, 4'hb, S_I, 0, 0);
    step(1, 0, 0, 4'hb, S_I, 0, 0);
    // Start, clear, then count 1..9 and wrap, MOD=9 up.
    step(0, 1, 0, 4'hb, S_C, 0, 0);
    step(0, 0, 0, 4'h0, S_R, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 0, 0, 4'(i), S_R, 0, 0);
    step(0, 0, 0, 4'h0, S_R, 1, 1);
    for (int i = 1; i <= 6; i++) step(0, 0, 0, 4'(i), S_R, 0, 1);
    // Pause at 6: step still happens, freeze at 7, resume without clear.
    step(0, 0, 1, 4'h7, S_H, 0, 1);
    repeat (5) step(0, 0, 0, 4'h7, S_H, 0, 1);
    step(0, 1, 0, 4'h7, S_R, 0, 1);
    step(0, 0, 0, 4'h8, S_R, 0, 1);
    step(0, 0, 0, 4'h9, S_R, 0, 1);
    step(0, 0, 0, 4'h0, S_R, 1, 2);
    for (int i = 1; i <= 7; i++) step(0, 0, 0, 4'(i), S_R, 0, 2);
    // Terminal count lowered to 3 at 7: natural overflow to 0 without DONE.
    cur_mod = 4'd3;
    for (int i = 8; i <= 15; i++) step(0, 0, 0, 4'(i), S_R, 0, 2);
    step(0, 0, 0, 4'h0, S_R, 0, 2);
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 4'(i), S_R, 0, 2);
    step(0, 0, 0, 4'h0, S_R, 1, 3);
    // Pause, then START+STOP in HOLD aborts; in IDLE nothing moves.
    step(0, 0, 1, 4'h1, S_H, 0, 3);
    step(0, 1, 1, 4'h1, S_I, 0, 3);
    repeat (3) step(0, 1, 1, 4'h1, S_I, 0, 3);
    // Down count MOD=5 from a clear; STOP is ignored during CLEAR.
    cur_dir = 1'b0; cur_mod = 4'd5;
    step(0, 1, 0, 4'h1, S_C, 0, 3);
    step(0, 0, 1, 4'h0, S_R, 0, 0);
    step(0, 0, 0, 4'h5, S_R, 1, 1);
    for (int i = 4; i >= 0; i--) step(0, 0, 0, 4'(i), S_R, 0, 1);
    step(0, 0, 0, 4'h5, S_R, 1, 2);
    step(0, 0, 0, 4'h4, S_R, 0, 2);
    // Direction flips take effect on the very next edge.
    cur_dir = 1'b1;
    step(0, 0, 0, 4'h5, S_R, 0, 2);
    cur_dir = 1'b0;
    step(0, 0, 0, 4'h4, S_R, 0, 2);
    // Down with value above MOD=2: run to 0, then reload 2.
    cur_mod = 4'd2;
    for (int i = 3; i >= 0; i--) step(0, 0, 0, 4'(i), S_R, 0, 2);
    step(0, 0, 0, 4'h2, S_R, 1, 3);
    // Reset mid-run: bank frozen, counters cleared.
    step(1, 0, 0, 4'h2, S_I, 0, 0);
    // Terminal count 0: value pinned at 0, DONE every cycle either direction, WRAPS rolls over.
    cur_mod = 4'd0; cur_dir = 1'b1;
    step(0, 1, 0, 4'h2, S_C, 0, 0);
    step(0, 0, 0, 4'h0, S_R, 0, 0);
    for (int i = 0; i <= 256; i++) begin
      cur_dir = i[0];
      step(0, 0, 0, 4'h0, S_R, 1, 8'(i + 1));
    end
    // Reset on the edge where Q_IN==MOD cancels the wrap.
    cur_mod = 4'd3; cur_dir = 1'b1;
    step(0, 0, 0, 4'h1, S_R, 0, 1);
    step(0, 0, 0, 4'h2, S_R, 0, 1);
    step(0, 0, 0, 4'h3, S_R, 0, 1);
    step(1, 0, 0, 4'h3, S_I, 0, 0);
    step(0, 0, 0, 4'h3, S_I, 0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge CP);
    #2;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
